// File: rtl/ibex_msg_pkg.sv
// Shared types and constants for the message transmit path.
package ibex_msg_pkg;

    localparam int MsgMaxWords = 4;
    localparam int MsgLenW     = 2;
    localparam int MsgAddrW    = 5;
    localparam int MsgDataW    = 32;

    typedef enum logic [1:0] {
        MsgTxIdle,
        MsgTxRead,
        MsgTxDrain
    } msg_tx_state_e;

    typedef struct packed {
        logic [MsgDataW-1:0] data;
        logic [MsgAddrW-1:0] addr;
        logic                last;
    } msg_beat_t;

    // RV32E has a 16-entry MPRF, so addresses wrap at 4 bits.
    function automatic logic [MsgAddrW-1:0] msg_addr_mask(input bit rv32e);
        return rv32e ? 5'h0F : 5'h1F;
    endfunction

endpackage

// File: rtl/ibex_msg_tx_fifo.sv
// Small pointer-based FIFO of message beats. The head entry is driven
// straight from the storage registers, so outputs never depend on pop_i.
module ibex_msg_tx_fifo import ibex_msg_pkg::*; #(
    parameter int  Depth  = 2,
    parameter type beat_t = msg_beat_t
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  flush_i,
    input  logic  push_i,
    input  beat_t wdata_i,
    input  logic  pop_i,
    output beat_t rdata_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    beat_t           r_mem [Depth];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [PtrW:0]   r_cnt;
    logic            w_push;
    logic            w_pop;

    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign w_pop   = pop_i & ~empty_o;
    assign w_push  = push_i & (~full_o | w_pop);
    assign full_o  = (r_cnt == (PtrW+1)'(Depth));
    assign empty_o = (r_cnt == '0);
    assign rdata_o = r_mem[r_rptr];

    // Storage, pointers and occupancy; flush empties without clearing data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= wdata_i;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/ibex_msg_tx.sv
// Message transmitter: reads 1-4 consecutive MPRF words and streams them
// out as (data, addr, last) beats over valid/ready.
module ibex_msg_tx import ibex_msg_pkg::*; #(
    parameter bit RV32E     = 1'b0,
    parameter int DataWidth = 32,
    parameter int FifoDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 send_valid_i,
    output logic                 send_ready_o,
    input  logic [MsgAddrW-1:0]  send_base_i,
    input  logic [MsgLenW-1:0]   send_len_i,
    input  logic                 flush_i,
    output logic                 rf_re_o,
    output logic [MsgAddrW-1:0]  rf_raddr_o,
    input  logic [DataWidth-1:0] rf_rdata_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic [MsgAddrW-1:0]  out_addr_o,
    output logic                 out_last_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic [MsgAddrW-1:0] AddrMask = msg_addr_mask(RV32E);
    localparam int                  RemW     = $clog2(MsgMaxWords + 1);

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [MsgAddrW-1:0]  addr;
        logic                 last;
    } beat_t;

    msg_tx_state_e       r_state, w_state_nxt;
    logic [MsgAddrW-1:0] r_ptr, w_ptr_nxt;
    logic [RemW-1:0]     r_rem, w_rem_nxt;
    logic                r_done, w_done_nxt;
    logic                w_read;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    beat_t               w_wbeat;
    beat_t               w_rbeat;

    assign w_pop         = out_valid_o & out_ready_i;
    assign w_wbeat.data  = rf_rdata_i;
    assign w_wbeat.addr  = r_ptr;
    assign w_wbeat.last  = (r_rem == RemW'(1));

    ibex_msg_tx_fifo #(
        .Depth  (FifoDepth),
        .beat_t (beat_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (w_read),
        .wdata_i (w_wbeat),
        .pop_i   (w_pop),
        .rdata_o (w_rbeat),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign rf_re_o     = w_read;
    assign rf_raddr_o  = w_read ? r_ptr : '0;
    assign out_valid_o = ~w_empty;
    assign out_data_o  = w_rbeat.data;
    assign out_addr_o  = w_rbeat.addr;
    assign out_last_o  = w_rbeat.last;
    assign busy_o      = (r_state != MsgTxIdle);
    assign done_o      = r_done;

    // Next-state, counter updates and read strobe; flush overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_rem_nxt    = r_rem;
        w_done_nxt   = 1'b0;
        w_read       = 1'b0;
        send_ready_o = 1'b0;
        unique case (r_state)
            MsgTxIdle: begin
                send_ready_o = 1'b1;
                if (send_valid_i && !flush_i) begin
                    w_ptr_nxt   = send_base_i & AddrMask;
                    w_rem_nxt   = RemW'(send_len_i) + RemW'(1);
                    w_state_nxt = MsgTxRead;
                end
            end
            MsgTxRead: begin
                // Read only when the beat has room, counting a same-cycle pop.
                if (!flush_i && (!w_full || w_pop)) begin
                    w_read    = 1'b1;
                    w_ptr_nxt = (r_ptr + 1'b1) & AddrMask;
                    w_rem_nxt = r_rem - 1'b1;
                    if (r_rem == RemW'(1)) w_state_nxt = MsgTxDrain;
                end
            end
            MsgTxDrain: begin
                if (w_pop && w_rbeat.last) begin
                    w_state_nxt = MsgTxIdle;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = MsgTxIdle;
        endcase
        if (flush_i) begin
            w_state_nxt = MsgTxIdle;
            w_done_nxt  = 1'b0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= MsgTxIdle;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_rem   <= w_rem_nxt;
            r_done  <= w_done_nxt;
        end
    end

endmodule
